// File: rtl/ram_seq_ctrl.sv
// Record/playback sequencer for the single-port pattern RAM: records a valid/ready
// input stream from address 0, replays it through a 2-entry buffer. SEQ_LOOP_EN adds looped playback.
module ram_seq_ctrl #(
    parameter int DWIDTH = 16,
    parameter int AWIDTH = 12,
    parameter int WORDS  = 4096
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_rec,
    input  logic              start_play,
    input  logic              stop,
    input  logic              in_valid,
    input  logic [DWIDTH-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DWIDTH-1:0] out_data,
`ifdef SEQ_LOOP_EN
    input  logic              loop,
`endif
    input  logic              out_ready,
    output logic              ram_load,
    output logic [AWIDTH-1:0] ram_addr,
    output logic [DWIDTH-1:0] ram_d,
    input  logic [DWIDTH-1:0] ram_q,
    output logic [AWIDTH:0]   rec_len,
    output logic              busy,
    output logic              done
);

    // Both streams: a word moves on every cycle where valid and ready are high together;
    // ready never looks at valid, and valid never looks at ready.
    typedef enum logic [1:0] {S_IDLE, S_REC, S_PLAY, S_DRAIN} state_t;

    localparam logic [AWIDTH:0] FULL = (AWIDTH+1)'(WORDS);
    localparam logic [AWIDTH:0] ONE  = (AWIDTH+1)'(1);
    localparam logic [AWIDTH:0] LAST = FULL - ONE;

    state_t              state_q, state_d;
    logic [AWIDTH:0]     wr_ptr_q, wr_ptr_d;
    logic [AWIDTH:0]     rec_len_q, rec_len_d;
    logic [AWIDTH:0]     rd_ptr_q, rd_ptr_d;
    logic                qv_q, qv_d;
    logic [DWIDTH-1:0]   fifo_mem_q [2];
    logic [DWIDTH-1:0]   fifo_mem_d [2];
    logic                fifo_wr_q, fifo_wr_d;
    logic                fifo_rd_q, fifo_rd_d;
    logic [1:0]          fifo_cnt_q, fifo_cnt_d;
    logic                done_q, done_d;

    logic                accept;
    logic                issue;
    logic                pop;
    logic                last_rd;
    logic                loop_en;
    logic [2:0]          occ;

`ifdef SEQ_LOOP_EN
    assign loop_en = loop;
`else
    assign loop_en = 1'b0;
`endif

    assign out_valid = (fifo_cnt_q != 2'd0);
    assign out_data  = fifo_mem_q[fifo_rd_q];
    assign pop       = out_valid && out_ready;
    assign last_rd   = ((rd_ptr_q + ONE) == rec_len_q);
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign rec_len   = rec_len_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rec_len_q  <= '0;
            rd_ptr_q   <= '0;
            qv_q       <= 1'b0;
            fifo_mem_q <= '{default: '0};
            fifo_wr_q  <= 1'b0;
            fifo_rd_q  <= 1'b0;
            fifo_cnt_q <= 2'd0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rec_len_q  <= rec_len_d;
            rd_ptr_q   <= rd_ptr_d;
            qv_q       <= qv_d;
            fifo_mem_q <= fifo_mem_d;
            fifo_wr_q  <= fifo_wr_d;
            fifo_rd_q  <= fifo_rd_d;
            fifo_cnt_q <= fifo_cnt_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rec_len_d  = rec_len_q;
        rd_ptr_d   = rd_ptr_q;
        qv_d       = issue;
        fifo_mem_d = fifo_mem_q;
        fifo_wr_d  = fifo_wr_q;
        fifo_rd_d  = fifo_rd_q;
        fifo_cnt_d = fifo_cnt_q + {1'b0, qv_q} - {1'b0, pop};
        done_d     = 1'b0;

        // A read issued last cycle lands in the buffer at this edge.
        if (qv_q) begin
            fifo_mem_d[fifo_wr_q] = ram_q;
            fifo_wr_d             = ~fifo_wr_q;
        end
        if (pop) begin
            fifo_rd_d = ~fifo_rd_q;
        end

        case (state_q)
            S_IDLE: begin
                if (!stop) begin
                    if (start_rec) begin
                        state_d   = S_REC;
                        wr_ptr_d  = '0;
                        rec_len_d = '0;
                    end else if (start_play) begin
                        if (rec_len_q != '0) begin
                            state_d  = S_PLAY;
                            rd_ptr_d = '0;
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end
            end
            S_REC: begin
                if (accept) begin
                    wr_ptr_d  = wr_ptr_q + ONE;
                    rec_len_d = rec_len_q + ONE;
                    if (wr_ptr_q == LAST) begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_PLAY: begin
                if (issue) begin
                    if (!last_rd) begin
                        rd_ptr_d = rd_ptr_q + ONE;
                    end else if (loop_en) begin
                        rd_ptr_d = '0;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end
            end
            default: begin
                if ((fifo_cnt_q == 2'd0) && !qv_q) begin
                    state_d = S_IDLE;
                end
            end
        endcase

        if (stop && (state_q != S_IDLE)) begin
            state_d    = S_IDLE;
            qv_d       = 1'b0;
            fifo_cnt_d = 2'd0;
            fifo_wr_d  = 1'b0;
            fifo_rd_d  = 1'b0;
        end

        if ((state_q != S_IDLE) && (state_d == S_IDLE)) begin
            done_d = 1'b1;
        end
    end

    always_comb begin
        in_ready = 1'b0;
        accept   = 1'b0;
        issue    = 1'b0;
        ram_load = 1'b0;
        ram_addr = '0;
        ram_d    = '0;
        occ      = {1'b0, fifo_cnt_q} + {2'b00, qv_q} - {2'b00, pop};

        case (state_q)
            S_REC: begin
                in_ready = !stop && (wr_ptr_q < FULL);
                accept   = in_valid && in_ready;
                if (accept) begin
                    ram_load = 1'b1;
                    ram_addr = wr_ptr_q[AWIDTH-1:0];
                    ram_d    = in_data;
                end
            end
            S_PLAY: begin
                // Never let buffered plus in-flight words exceed the two buffer slots.
                issue = !stop && (occ < 3'd2);
                if (issue) begin
                    ram_addr = rd_ptr_q[AWIDTH-1:0];
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_ram_seq_ctrl.sv
// Bench for ram_seq_ctrl: behavioural RAM, pattern model with expected-word queue,
// randomized valid/ready stimulus. The loop scenario is compiled in with SEQ_LOOP_EN.
module tb_ram_seq_ctrl;

    localparam int DW    = 16;
    localparam int AW    = 12;
    localparam int WORDS = 4096;

    logic          clk;
    logic          rst_n;
    logic          start_rec;
    logic          start_play;
    logic          stop;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready;
    logic          ram_load;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_d;
    logic [DW-1:0] ram_q;
    logic [AW:0]   rec_len;
    logic          busy;
    logic          done;
`ifdef SEQ_LOOP_EN
    logic          loop_in;
`endif

    int            n_checks;
    int            n_errors;
    int            ref_len;
    int            n_pop;
    logic [DW-1:0] ref_mem [WORDS];
    logic [DW-1:0] pat [WORDS];
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] ram_mem [WORDS];

    ram_seq_ctrl #(.DWIDTH(DW), .AWIDTH(AW), .WORDS(WORDS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_rec  (start_rec),
        .start_play (start_play),
        .stop       (stop),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
`ifdef SEQ_LOOP_EN
        .loop       (loop_in),
`endif
        .out_ready  (out_ready),
        .ram_load   (ram_load),
        .ram_addr   (ram_addr),
        .ram_d      (ram_d),
        .ram_q      (ram_q),
        .rec_len    (rec_len),
        .busy       (busy),
        .done       (done)
    );

    // Clock and pattern RAM (1-cycle read, write-then-read on the same address).
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (ram_load) begin
            ram_mem[ram_addr] <= ram_d;
            ram_q             <= ram_d;
        end else begin
            ram_q <= ram_mem[ram_addr];
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard: sampled at the falling edge with inputs stable.
    task automatic monitor();
        check("rec_len_track", 32'(rec_len), ref_len);
        if (in_valid && in_ready) begin
            check("wr_load", 32'(ram_load), 1);
            check("wr_addr", 32'(ram_addr), ref_len % WORDS);
            check("wr_data", 32'(ram_d), 32'(in_data));
            if (ref_len < WORDS) ref_mem[ref_len] = in_data;
            ref_len++;
        end else begin
            check("no_write", 32'(ram_load), 0);
        end
        if (!busy) begin
            check("idle_addr", 32'(ram_addr), 0);
            check("idle_d", 32'(ram_d), 0);
            check("idle_ready", 32'(in_ready), 0);
        end
        if (out_valid && out_ready) begin
            check("out_expected", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) check("out_data", 32'(out_data), 32'(exp_q.pop_front()));
            n_pop++;
        end
    endtask

    task automatic do_cycle();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 0);
        check({tag, "_out_valid"}, 32'(out_valid), 0);
        check({tag, "_out_data"}, 32'(out_data), 0);
        check({tag, "_ram_load"}, 32'(ram_load), 0);
        check({tag, "_ram_addr"}, 32'(ram_addr), 0);
        check({tag, "_ram_d"}, 32'(ram_d), 0);
        check({tag, "_rec_len"}, 32'(rec_len), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
    endtask

    function automatic logic ready_for(input int mode, input int cyc);
        if (mode == 0) return 1'b1;
        if (mode == 1) return ((cyc % 4) == 0) || ((cyc % 4) == 3);
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic record(input int n, input bit rnd, input bit stop_after);
        int cyc;
        bit seen;
        start_rec = 1'b1;
        check("rec_ready_c0", 32'(in_ready), 0);
        do_cycle();
        start_rec = 1'b0;
        ref_len = 0;
        check("rec_ready_c1", 32'(in_ready), 1);
        check("rec_busy", 32'(busy), 1);
        cyc = 0;
        while (ref_len < n && cyc < 4 * n + 50) begin
            in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data  = pat[ref_len];
            do_cycle();
            cyc++;
        end
        check("rec_count", ref_len, n);
        in_valid = 1'b0;
        if (stop_after) begin
            stop = 1'b1;
            do_cycle();
            stop = 1'b0;
            check("rec_stop_done", 32'(done), 1);
            check("rec_stop_busy", 32'(busy), 0);
        end else begin
            in_valid = 1'b1;
            seen = 1'b0;
            for (int k = 0; k < 4 && !seen; k++) begin
                check("full_in_ready", 32'(in_ready), 0);
                if (done) seen = 1'b1;
                else do_cycle();
            end
            in_valid = 1'b0;
            check("full_done", 32'(seen), 1);
            do_cycle();
            check("full_done_1cyc", 32'(done), 0);
        end
        check("rec_len_out", 32'(rec_len), n);
    endtask

    task automatic play(input int mode, input int stop_at);
        int  cyc, lat, first_pop, last_pop, pops0, budget;
        bit  seen_done, stopped;
        for (int i = 0; i < ref_len; i++) exp_q.push_back(ref_mem[i]);
        n_pop = 0; lat = -1; first_pop = -1; last_pop = -1;
        seen_done = 1'b0; stopped = 1'b0; cyc = 0;
        budget = 40 + 4 * ref_len;
        start_play = 1'b1;
        while (cyc < budget && !seen_done && !stopped) begin
            out_ready = ready_for(mode, cyc);
            if (stop_at > 0 && n_pop >= stop_at) begin
                stop = 1'b1;
                do_cycle();
                stop = 1'b0;
                check("stop_out_valid", 32'(out_valid), 0);
                check("stop_busy", 32'(busy), 0);
                check("stop_done", 32'(done), 1);
                check("stop_rec_len", 32'(rec_len), ref_len);
                exp_q.delete();
                do_cycle();
                check("stop_done_1cyc", 32'(done), 0);
                check("stop_still_idle", 32'(out_valid), 0);
                stopped = 1'b1;
            end else begin
                pops0 = n_pop;
                do_cycle();
                start_play = 1'b0;
                cyc++;
                if (n_pop != pops0) begin
                    if (first_pop < 0) first_pop = cyc - 1;
                    last_pop = cyc - 1;
                end
                if (out_valid && lat < 0) lat = cyc;
                if (done) seen_done = 1'b1;
            end
        end
        start_play = 1'b0;
        check("play_lat", lat, 3);
        if (!stopped) begin
            check("play_done", 32'(seen_done), 1);
            check("play_left", exp_q.size(), 0);
            check("play_count", n_pop, ref_len);
            check("play_busy_end", 32'(busy), 0);
            if (mode == 0) check("play_burst", last_pop - first_pop, ref_len - 1);
            do_cycle();
            check("play_done_1cyc", 32'(done), 0);
        end
        out_ready = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        n_checks = 0; n_errors = 0; ref_len = 0; n_pop = 0;
        rst_n = 1'b0; start_rec = 1'b0; start_play = 1'b0; stop = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
`ifdef SEQ_LOOP_EN
        loop_in = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        rst_n = 1'b1;
        do_cycle();

        // Empty pattern: no playback, done one cycle later.
        start_play = 1'b1;
        do_cycle();
        start_play = 1'b0;
        check("empty_done", 32'(done), 1);
        check("empty_busy", 32'(busy), 0);
        check("empty_out_valid", 32'(out_valid), 0);
        do_cycle();
        check("empty_done_1cyc", 32'(done), 0);

        // Five fixed words, then full-rate and patterned backpressure playback.
        for (int i = 0; i < 5; i++) pat[i] = DW'((i + 1) * 16'h1111);
        record(5, 1'b0, 1'b1);
        play(0, 0);
        play(1, 0);

        // Stop two words into playback.
        play(0, 2);
        check("after_stop_rec_len", 32'(rec_len), 5);

        // Random patterns with random valid and ready.
        for (int t = 0; t < 3; t++) begin
            int n;
            n = $urandom_range(6, 40);
            for (int i = 0; i < n; i++) pat[i] = DW'($urandom);
            record(n, 1'b1, 1'b1);
            play(2, 0);
        end

        // Reset in the middle of recording.
        for (int i = 0; i < 8; i++) pat[i] = DW'($urandom);
        start_rec = 1'b1;
        do_cycle();
        start_rec = 1'b0;
        ref_len = 0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = pat[ref_len];
            do_cycle();
        end
        #2 rst_n = 1'b0;
        #1;
        check_zero_outputs("midrst");
        in_valid = 1'b0;
        ref_len = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        do_cycle();
        check("midrst_rec_len", 32'(rec_len), 0);

        // Fill the whole RAM with an incrementing pattern and play it back.
        for (int i = 0; i < WORDS; i++) pat[i] = DW'(i);
        record(WORDS, 1'b0, 1'b0);
        play(0, 0);

`ifdef SEQ_LOOP_EN
        begin
            int  cyc;
            bit  seen_done;
            pat[0] = 16'hA0A0; pat[1] = 16'hB1B1; pat[2] = 16'hC2C2;
            record(3, 1'b0, 1'b1);
            loop_in = 1'b1;
            for (int p = 0; p < 40; p++) begin
                for (int i = 0; i < 3; i++) exp_q.push_back(ref_mem[i]);
            end
            n_pop = 0; cyc = 0; seen_done = 1'b0;
            start_play = 1'b1;
            while (n_pop < 20 && cyc < 200) begin
                out_ready = 1'($urandom_range(0, 1));
                do_cycle();
                start_play = 1'b0;
                cyc++;
            end
            check("loop_busy", 32'(busy), 1);
            loop_in = 1'b0;
            cyc = 0;
            while (!seen_done && cyc < 100) begin
                out_ready = 1'($urandom_range(0, 1));
                do_cycle();
                cyc++;
                if (done) seen_done = 1'b1;
            end
            check("loop_done", 32'(seen_done), 1);
            check("loop_pass_end", n_pop % 3, 0);
            check("loop_min_words", 32'(n_pop >= 21), 1);
            out_ready = 1'b0;
            exp_q.delete();
        end
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
